// File: rtl/shift_add_control.sv
// Sequential control and datapath for a 32x32 unsigned shift-add multiplier.
// Drives an external combinational ALU and shifts its sum/carry back into the product register.
module shift_add_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic [63:0] Product,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_NOP = 6'b000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q,  prod_d;

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch; state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        alu_funct = FUNCT_NOP;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mcand_d = Multiplicand;
                    prod_d  = {32'b0, Multiplier};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                // The ALU returns zero for a non-add code, so the no-add path must bypass it.
                if (prod_q[0]) begin
                    alu_funct = FUNCT_ADD;
                    prod_d    = {alu_carry, alu_result, prod_q[31:1]};
                end else begin
                    prod_d    = {1'b0, prod_q[63:32], prod_q[31:1]};
                end
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_src1 = mcand_q;
    assign alu_src2 = prod_q[63:32];
    assign Product  = prod_q;

endmodule
